ram_sp: RTL

Parametrised single-port synchronous RAM with separate read and write data buses, per-byte write enables, registered read with a valid strobe, and a built-in clear sequencer. After reset or a `clr` pulse it zero-fills every location, one per cycle, before accepting requests. It is the general-purpose storage block for register files, scratch buffers and lookup memories in the datapath.

---
 rtl/ram_pkg.sv | 13 +
 rtl/ram_clr_seq.sv | 77 +++++++
 rtl/ram_sp.sv | 131 +++++++++++++
 3 files changed

// File: rtl/ram_pkg.sv
// ram_pkg: shared definitions for the ram_sp storage block.
//   RAM_BYTE_W  - width of one byte lane controlled by a single byte enable
//   ram_state_t - clear sequencer states (RAM_CLEAR zero-fills, RAM_IDLE serves requests)
package ram_pkg;

    localparam int RAM_BYTE_W = 8;

    typedef enum logic [0:0] {
        RAM_CLEAR = 1'b0,
        RAM_IDLE  = 1'b1
    } ram_state_t;

endpackage

// File: rtl/ram_clr_seq.sv
// ram_clr_seq: clear sequencer for ram_sp. After reset or a clr pulse it walks
// clr_cnt from 0 to DEPTH-1, asserting clr_we so the storage writes zero to
// each location, then enters IDLE and raises ready.
// Ports:
//   clk      in  - rising-edge clock
//   rst_n    in  - synchronous active-low reset (enters CLEAR, counter 0)
//   clr      in  - restart the clear sequence
//   ready    out - 1 in IDLE, 0 while clearing
//   clr_we   out - zero-write strobe for the storage array
//   clr_addr out - location being zeroed this cycle
module ram_clr_seq
    import ram_pkg::*;
#(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    output logic              ready,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    ram_state_t        state_q;
    ram_state_t        state_d;
    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] cnt_d;

    // Next-state logic: clr always restarts the fill from location 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RAM_CLEAR: begin
                if (clr) begin
                    cnt_d = {ADDR_W{1'b0}};
                end else if (cnt_q == LAST_ADDR) begin
                    state_d = RAM_IDLE;
                    cnt_d   = {ADDR_W{1'b0}};
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1'b1);
                end
            end
            RAM_IDLE: begin
                if (clr) begin
                    state_d = RAM_CLEAR;
                    cnt_d   = {ADDR_W{1'b0}};
                end else begin
                    cnt_d = {ADDR_W{1'b0}};
                end
            end
            default: begin
                state_d = RAM_CLEAR;
                cnt_d   = {ADDR_W{1'b0}};
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RAM_CLEAR;
            cnt_q   <= {ADDR_W{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ready    = (state_q == RAM_IDLE);
    assign clr_we   = (state_q == RAM_CLEAR);
    assign clr_addr = cnt_q;

endmodule

// File: rtl/ram_sp.sv
// ram_sp: single-port synchronous RAM with byte-enabled writes, registered
// read data with a valid strobe, out-of-range detection and a built-in
// zero-fill sequencer that runs after reset or clr.
// Ports:
//   clk, rst_n  in  - clock, synchronous active-low reset
//   clr         in  - restart zero-fill (any request in that cycle is dropped)
//   req, we     in  - access request (accepted when req & ready), 1 = write
//   addr        in  - word address
//   be          in  - byte enables for writes
//   wdata       in  - write data
//   ready       out - high when requests can be accepted
//   rdata       out - registered read data, held between reads
//   rvalid      out - strobe the cycle after an accepted read
//   addr_err    out - strobe the cycle after an accepted access with addr >= DEPTH
module ram_sp
    import ram_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [BE_W-1:0]   be,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              addr_err
);

    // One extra bit so DEPTH itself is representable when DEPTH is a power of two.
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              clr_we_s;
    logic [ADDR_W-1:0] clr_addr_s;
    logic              accept_s;
    logic              in_range_s;
    logic              user_we_s;
    logic              user_rd_s;
    logic [DATA_W-1:0] rd_word_s;
    logic [DATA_W-1:0] wr_word_s;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;
    logic              rvalid_q;
    logic              addr_err_q;

    ram_clr_seq #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clr_seq (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .ready    (ready),
        .clr_we   (clr_we_s),
        .clr_addr (clr_addr_s)
    );

    // A clr in IDLE wins over a simultaneous request; reset overrides everything.
    assign accept_s   = rst_n & req & ready & ~clr;
    assign in_range_s = ({1'b0, addr} < DEPTH_X);
    assign user_we_s  = accept_s & we & in_range_s;
    assign user_rd_s  = accept_s & ~we;

    // Current word at addr; out-of-range reads return zero.
    always_comb begin
        if (in_range_s) begin
            rd_word_s = mem_q[addr];
        end else begin
            rd_word_s = {DATA_W{1'b0}};
        end
    end

    // Merge enabled byte lanes of wdata into the current word.
    always_comb begin
        wr_word_s = rd_word_s;
        for (int i = 0; i < BE_W; i++) begin
            if (be[i]) begin
                wr_word_s[i*RAM_BYTE_W +: RAM_BYTE_W] = wdata[i*RAM_BYTE_W +: RAM_BYTE_W];
            end else begin
                wr_word_s[i*RAM_BYTE_W +: RAM_BYTE_W] = rd_word_s[i*RAM_BYTE_W +: RAM_BYTE_W];
            end
        end
    end

    // Storage write port: clear-sequencer zero-fill or user write; reset leaves contents alone.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (clr_we_s) begin
                mem_q[clr_addr_s] <= {DATA_W{1'b0}};
            end else if (user_we_s) begin
                mem_q[addr] <= wr_word_s;
            end
        end
    end

    // Read data only changes on an accepted read.
    always_comb begin
        if (user_rd_s) begin
            rdata_d = rd_word_s;
        end else begin
            rdata_d = rdata_q;
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q    <= {DATA_W{1'b0}};
            rvalid_q   <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            rdata_q    <= rdata_d;
            rvalid_q   <= user_rd_s;
            addr_err_q <= accept_s & ~in_range_s;
        end
    end

    assign rdata    = rdata_q;
    assign rvalid   = rvalid_q;
    assign addr_err = addr_err_q;

endmodule
